// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline sequencing controller for the 5-stage core. Decides
//                per cycle which pipeline registers hold or load a bubble for
//                data-memory wait, multi-cycle MDU occupancy, EX redirects
//                and load-use hazards; keeps saturating stall/flush counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int MDU_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_uses_rs1_i,
    input  logic        id_uses_rs2_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_mem_read_i,
    input  logic        ex_redirect_i,
    input  logic        ex_mdu_start_i,
    input  logic        mem_req_i,
    input  logic        mem_ready_i,
    output logic        pc_stall_o,
    output logic        if_id_stall_o,
    output logic        if_id_flush_o,
    output logic        id_ex_stall_o,
    output logic        id_ex_flush_o,
    output logic        ex_mem_stall_o,
    output logic        ex_mem_flush_o,
    output logic        mem_wb_flush_o,
    output logic        mdu_done_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    localparam logic [1:0] c_RUN      = 2'd0;
    localparam logic [1:0] c_MDU_BUSY = 2'd1;
    localparam logic [1:0] c_MEM_WAIT = 2'd2;

    // First MDU cycle is spent in RUN and the last one (cnt==0) releases the
    // pipeline, so the busy countdown starts at MDU_LAT-2.
    localparam logic [3:0] c_CNT_LOAD = 4'(MDU_LAT - 2);

    logic [1:0]  r_state;
    logic        r_ret_mdu;     // state to resume after a memory wait: 1 = MDU_BUSY
    logic [3:0]  r_cnt;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    logic [1:0]  w_state_nxt;
    logic        w_ret_mdu_nxt;
    logic [3:0]  w_cnt_nxt;
    logic [1:0]  w_eff_state;
    logic        w_memw;
    logic        w_load_use;

    // State, MDU countdown and return-state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_RUN;
            r_ret_mdu <= 1'b0;
            r_cnt     <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_ret_mdu <= w_ret_mdu_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // Prioritised hazard resolution; MEM_WAIT is treated as the remembered
    // state once memory is ready so that cycle is evaluated by the lower rules
    always_comb begin
        w_memw      = mem_req_i & ~mem_ready_i;
        w_load_use  = ex_mem_read_i & (ex_rd_i != 5'd0) &
                      ((id_uses_rs1_i & (id_rs1_i == ex_rd_i)) |
                       (id_uses_rs2_i & (id_rs2_i == ex_rd_i)));
        w_eff_state = (r_state == c_MEM_WAIT) ? (r_ret_mdu ? c_MDU_BUSY : c_RUN)
                                              : r_state;

        w_state_nxt    = w_eff_state;
        w_ret_mdu_nxt  = r_ret_mdu;
        w_cnt_nxt      = r_cnt;
        pc_stall_o     = 1'b0;
        if_id_stall_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_stall_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_stall_o = 1'b0;
        ex_mem_flush_o = 1'b0;
        mem_wb_flush_o = 1'b0;
        mdu_done_o     = 1'b0;

        if (rst_n) begin
            if (w_memw) begin
                // Whole front of the pipe freezes; MDU progress is deferred
                pc_stall_o     = 1'b1;
                if_id_stall_o  = 1'b1;
                id_ex_stall_o  = 1'b1;
                ex_mem_stall_o = 1'b1;
                mem_wb_flush_o = 1'b1;
                w_state_nxt    = c_MEM_WAIT;
                w_ret_mdu_nxt  = (w_eff_state == c_MDU_BUSY);
            end else if (((w_eff_state == c_RUN) && ex_mdu_start_i) ||
                         ((w_eff_state == c_MDU_BUSY) && (r_cnt != 4'd0))) begin
                pc_stall_o     = 1'b1;
                if_id_stall_o  = 1'b1;
                id_ex_stall_o  = 1'b1;
                ex_mem_flush_o = 1'b1;
                w_state_nxt    = c_MDU_BUSY;
                w_cnt_nxt      = (w_eff_state == c_RUN) ? c_CNT_LOAD : (r_cnt - 4'd1);
            end else if (w_eff_state == c_MDU_BUSY) begin
                mdu_done_o  = 1'b1;
                w_state_nxt = c_RUN;
            end else if (ex_redirect_i) begin
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
            end else if (w_load_use) begin
                pc_stall_o    = 1'b1;
                if_id_stall_o = 1'b1;
                id_ex_flush_o = 1'b1;
            end
        end
    end

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (pc_stall_o && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (if_id_flush_o && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    // Counters read as zero while reset is held
    always_comb begin
        stall_cnt_o = rst_n ? r_stall_cnt : 32'd0;
        flush_cnt_o = rst_n ? r_flush_cnt : 32'd0;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage core. Every cycle it decides which pipeline registers hold (stall) and which load a bubble (flush), covering data-memory wait, multi-cycle MDU occupancy, EX-resolved control redirects and load-use hazards. It drives the `stall_i`/`flush_i` controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC enable, and keeps saturating stall and flush event counters.

## Interface
- `MDU_LAT`, default 4: cycles a mul/div instruction occupies EX. Legal range is 2..16.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `id_rs1_i`, `id_rs2_i` in 5: source registers of the instruction in ID.
- `id_uses_rs1_i`, `id_uses_rs2_i` in 1: the ID instruction reads that source.
- `ex_rd_i` in 5: destination of the instruction in EX.
- `ex_mem_read_i` in 1: the EX instruction is a load.
- `ex_redirect_i` in 1: branch taken or jump resolved in EX.
- `ex_mdu_start_i` in 1: the EX instruction is a multi-cycle MDU op. Held high while it sits in EX.
- `mem_req_i` in 1: the MEM instruction accesses data memory.
- `mem_ready_i` in 1: data memory completes this cycle.
- `pc_stall_o` out 1: hold the PC.
- `if_id_stall_o` out 1: hold IF/ID.
- `if_id_flush_o` out 1: IF/ID loads a NOP (0x00000013).
- `id_ex_stall_o` out 1: hold ID/EX.
- `id_ex_flush_o` out 1: ID/EX loads a bubble.
- `ex_mem_stall_o` out 1: hold EX/MEM.
- `ex_mem_flush_o` out 1: EX/MEM loads a bubble.
- `mem_wb_flush_o` out 1: MEM/WB loads a bubble.
- `mdu_done_o` out 1: the final EX cycle of an MDU op.
- `stall_cnt_o` out 32: cycles with `pc_stall_o`=1, saturating.
- `flush_cnt_o` out 32: cycles with `if_id_flush_o`=1, saturating.

## Operation
- State machine with states RUN, MDU_BUSY and MEM_WAIT, plus a 4-bit counter `cnt`.
- `memw` = `mem_req_i` & !`mem_ready_i`.
- Condition priority, evaluated combinationally each cycle:
  1. **Memory wait (`memw`).** Assert `pc_stall_o`, `if_id_stall_o`, `id_ex_stall_o`, `ex_mem_stall_o` and `mem_wb_flush_o`. No other flush. A redirect or MDU progress in this cycle is deferred: `cnt` holds. The next state is MEM_WAIT; the state to return to is remembered as RUN or MDU_BUSY.
  2. **MDU start in RUN** (`ex_mdu_start_i`=1), or **MDU_BUSY** with `cnt`≠0. Assert `pc_stall_o`, `if_id_stall_o`, `id_ex_stall_o` and `ex_mem_flush_o`.
     - From RUN: load `cnt` with MDU_LAT-2 and go to MDU_BUSY.
     - In MDU_BUSY: decrement `cnt`.
  3. **MDU_BUSY with `cnt`=0.** No stall. Pulse `mdu_done_o`=1 and go to RUN. `ex_mdu_start_i` is ignored throughout MDU_BUSY.
  4. **Redirect** (`ex_redirect_i`). Assert `if_id_flush_o` and `id_ex_flush_o`. No stall. Redirect overrides load-use in the same cycle.
  5. **Load-use.** Condition: `ex_mem_read_i` & (`ex_rd_i`≠0) & ((`id_uses_rs1_i` & `id_rs1_i`==`ex_rd_i`) | (`id_uses_rs2_i` & `id_rs2_i`==`ex_rd_i`)). Assert `pc_stall_o`, `if_id_stall_o` and `id_ex_flush_o`, which inserts exactly one bubble.
- In MEM_WAIT, the first cycle with `memw`=0 returns to the remembered state, and that cycle is evaluated by rules 2–5.
- A stall and a flush on the same register are never asserted together.
- Counters increment by 1 per qualifying cycle and stop at 0xFFFF_FFFF; they do not wrap.

## Timing
- All stall/flush outputs and `mdu_done_o` are combinational from the current state, `cnt` and the inputs. They take effect at the next clk edge.
- State, `cnt` and the counters update on the clk edge.
- An MDU op spends exactly MDU_LAT cycles in EX, giving MDU_LAT-1 stall cycles, plus any memory-wait cycles that interleave.
- A redirect and a load-use hazard each cost a fixed penalty: 2 flushed slots for a redirect, 1 bubble for load-use.
- Reset (synchronous, `rst_n`=0): state RUN, `cnt`=0, both counters 0. While `rst_n`=0 all outputs are 0. Reset in mid-MDU or mid-wait abandons the sequence immediately.

## Test plan
- **Load-use.** `ex_mem_read_i`=1, `ex_rd_i`=5, `id_rs2_i`=5, `id_uses_rs2_i`=1 → one cycle of `pc_stall_o`=`if_id_stall_o`=`id_ex_flush_o`=1, `stall_cnt_o`=1. Repeat with `ex_rd_i`=0 → no stall.
- **Redirect with load-use.** Both asserted in the same cycle → `if_id_flush_o`=`id_ex_flush_o`=1, `pc_stall_o`=0, `flush_cnt_o`=1.
- **MDU, MDU_LAT=4.** `ex_mdu_start_i` held 4 cycles → stalls in cycles 0–2, `mdu_done_o`=1 in cycle 3, `stall_cnt_o`=3.
- **Memory wait inside MDU.** `memw`=1 for 2 cycles starting at cycle 1 of an MDU op → all four stalls plus `mem_wb_flush_o` for those 2 cycles, `cnt` frozen, `mdu_done_o` at cycle 5, `stall_cnt_o`=5.
- **Reset mid-MDU.** `rst_n`=0 at cycle 1 of an MDU op → next cycle RUN, all outputs 0, counters 0.
- **Saturation.** Force `stall_cnt_o` to 0xFFFF_FFFE, apply 3 stall cycles → `stall_cnt_o` reads 0xFFFF_FFFF.
